// File: rtl/fill_arbiter_pkg.sv
// Shared definitions for the fill arbiter: field widths, tag-word layout,
// source and state encodings, and the helpers that build the AW address and
// the stored tag word.
package fill_arbiter_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int ID_WIDTH     = 4;
    localparam int TAG_WIDTH    = 16;
    localparam int BLANK_WIDTH  = 2;
    localparam int INDEX_WIDTH  = 10;
    localparam int OFFSET_WIDTH = 6;
    localparam int TAG_SIZE     = 2 + TAG_WIDTH + BLANK_WIDTH;

    // Low address bits that select the cache location; the rest is the tag.
    localparam int LOC_WIDTH    = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int REQ_WIDTH    = ADDR_WIDTH + DATA_WIDTH;
    localparam int WORD_WIDTH   = TAG_SIZE + DATA_WIDTH;

    // Tag-word bit positions.
    localparam int VALID_BIT    = TAG_SIZE - 1;
    localparam int DIRTY_BIT    = TAG_SIZE - 2;

    typedef enum logic {
        SRC_FILL   = 1'b0,
        SRC_REFILL = 1'b1
    } src_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    // Cache location: tag bits cleared, index/offset bits kept.
    function automatic logic [ADDR_WIDTH-1:0] make_awaddr(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] loc;
        loc                = {ADDR_WIDTH{1'b0}};
        loc[LOC_WIDTH-1:0] = addr[LOC_WIDTH-1:0];
        return loc;
    endfunction

    // Stored tag word: {VALID, DIRTY, tag bits of the address, blank zeros}.
    function automatic logic [TAG_SIZE-1:0] make_tag_word(input logic [ADDR_WIDTH-1:0] addr,
                                                          input logic dirty);
        logic [TAG_SIZE-1:0] word;
        word                              = {TAG_SIZE{1'b0}};
        word[VALID_BIT]                   = 1'b1;
        word[DIRTY_BIT]                   = dirty;
        word[BLANK_WIDTH +: TAG_WIDTH]    = addr[ADDR_WIDTH-1:LOC_WIDTH];
        return word;
    endfunction

endpackage

// File: rtl/fill_arbiter_if.sv
// Request and AXI write-channel bundle of the fill arbiter. The master
// modport is the arbiter's view; slave is the surrounding environment.
interface fill_arbiter_if;
    import fill_arbiter_pkg::*;

    logic                     fill_valid_i;
    logic                     fill_ready_o;
    logic [REQ_WIDTH-1:0]     fill_data_i;
    logic                     refill_valid_i;
    logic                     refill_ready_o;
    logic [REQ_WIDTH-1:0]     refill_data_i;
    logic [ID_WIDTH-1:0]      awid_o;
    logic [ADDR_WIDTH-1:0]    awaddr_o;
    logic                     awvalid_o;
    logic                     awready_i;
    logic [WORD_WIDTH-1:0]    wdata_o;
    logic                     wvalid_o;
    logic                     wlast_o;
    logic                     wready_i;
    logic [ID_WIDTH-1:0]      bid_i;
    logic                     bvalid_i;
    logic                     bready_o;

    modport master (
        input  fill_valid_i, fill_data_i, refill_valid_i, refill_data_i,
               awready_i, wready_i, bid_i, bvalid_i,
        output fill_ready_o, refill_ready_o, awid_o, awaddr_o, awvalid_o,
               wdata_o, wvalid_o, wlast_o, bready_o
    );

    modport slave (
        output fill_valid_i, fill_data_i, refill_valid_i, refill_data_i,
               awready_i, wready_i, bid_i, bvalid_i,
        input  fill_ready_o, refill_ready_o, awid_o, awaddr_o, awvalid_o,
               wdata_o, wvalid_o, wlast_o, bready_o
    );

endinterface

// File: rtl/fill_rr_arb.sv
// Two-requester grant for fill vs refill. With FILL_ARB_RR_EN defined the
// favoured source alternates after every grant (starting with fill);
// otherwise the pointer stays parked on refill, giving refill fixed priority.
// Requests must already be qualified, so every grant is a completed accept.
module fill_rr_arb
    import fill_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_fill,
    input  logic req_refill,
    output logic gnt_fill,
    output logic gnt_refill
);

    src_e ptr_r;

    // Pick one requester; on contention the pointer's source wins.
    always_comb begin
        gnt_fill   = 1'b0;
        gnt_refill = 1'b0;
        if (req_fill && req_refill) begin
            if (ptr_r == SRC_FILL) begin
                gnt_fill = 1'b1;
            end else begin
                gnt_refill = 1'b1;
            end
        end else if (req_fill) begin
            gnt_fill = 1'b1;
        end else if (req_refill) begin
            gnt_refill = 1'b1;
        end else begin
            gnt_fill   = 1'b0;
            gnt_refill = 1'b0;
        end
    end

`ifdef FILL_ARB_RR_EN
    // Hand preference to the other source after each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= SRC_FILL;
        end else if (gnt_fill) begin
            ptr_r <= SRC_REFILL;
        end else if (gnt_refill) begin
            ptr_r <= SRC_FILL;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Refill always preferred so read-miss data lands in the cache first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= SRC_REFILL;
        end else begin
            ptr_r <= SRC_REFILL;
        end
    end
`endif

endmodule

// File: rtl/fill_arbiter.sv
// Merges tag-comparator fills and backing-memory refills into single-beat
// AXI writes of {tag word, data}, limiting writes awaiting B responses.
// Optional macro FILL_ARB_RR_EN selects round-robin instead of refill-first.
module fill_arbiter
    import fill_arbiter_pkg::*;
#(
    parameter logic [ID_WIDTH-1:0] FILL_AXI_ID     = {ID_WIDTH{1'b0}},
    parameter int                  MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fill_arbiter_if.master       bus
);

    localparam int                CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e                  state_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic [ADDR_WIDTH-1:0]   awaddr_r;
    logic [WORD_WIDTH-1:0]   wdata_r;
    logic [CNT_W-1:0]        out_cnt_r;

    logic                    full_s;
    logic                    elig_fill_s;
    logic                    elig_refill_s;
    logic                    gnt_fill_s;
    logic                    gnt_refill_s;
    logic                    accept_s;
    logic                    b_dec_s;
    logic                    aw_done_s;
    logic                    w_done_s;
    logic [REQ_WIDTH-1:0]    sel_req_s;
    logic                    sel_dirty_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;

    assign full_s        = (out_cnt_r == CNT_MAX);
    assign elig_fill_s   = bus.fill_valid_i   && (state_r == S_IDLE) && !full_s;
    assign elig_refill_s = bus.refill_valid_i && (state_r == S_IDLE) && !full_s;
    assign accept_s      = gnt_fill_s || gnt_refill_s;
    assign b_dec_s       = bus.bvalid_i && (out_cnt_r != CNT_ZERO);
    assign aw_done_s     = !awvalid_r || bus.awready_i;
    assign w_done_s      = !wvalid_r  || bus.wready_i;
    assign sel_addr_s    = sel_req_s[REQ_WIDTH-1 -: ADDR_WIDTH];
    assign sel_data_s    = sel_req_s[DATA_WIDTH-1:0];

    fill_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_fill   (elig_fill_s),
        .req_refill (elig_refill_s),
        .gnt_fill   (gnt_fill_s),
        .gnt_refill (gnt_refill_s)
    );

    // Payload and DIRTY bit of the granted source (fill = dirty write data).
    always_comb begin
        sel_req_s   = bus.fill_data_i;
        sel_dirty_s = 1'b1;
        if (gnt_refill_s) begin
            sel_req_s   = bus.refill_data_i;
            sel_dirty_s = 1'b0;
        end else begin
            sel_req_s   = bus.fill_data_i;
            sel_dirty_s = 1'b1;
        end
    end

    // Accept/issue FSM: capture on accept, hold AW and W until each handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            awaddr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= {WORD_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        awaddr_r  <= make_awaddr(sel_addr_s);
                        wdata_r   <= {make_tag_word(sel_addr_s, sel_dirty_s), sel_data_s};
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        state_r   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (awvalid_r && bus.awready_i) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && bus.wready_i) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Writes awaiting B: up on accept, down on B, a stale B at zero is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_r <= CNT_ZERO;
        end else begin
            case ({accept_s, b_dec_s})
                2'b10:   out_cnt_r <= out_cnt_r + CNT_ONE;
                2'b01:   out_cnt_r <= out_cnt_r - CNT_ONE;
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

    assign bus.fill_ready_o   = gnt_fill_s;
    assign bus.refill_ready_o = gnt_refill_s;
    assign bus.awid_o         = FILL_AXI_ID;
    assign bus.awaddr_o       = awaddr_r;
    assign bus.awvalid_o      = awvalid_r;
    assign bus.wdata_o        = wdata_r;
    assign bus.wvalid_o       = wvalid_r;
    assign bus.wlast_o        = 1'b1;
    assign bus.bready_o       = 1'b1;

endmodule

// File: tb/tb_fill_arbiter.sv
// Directed bench for fill_arbiter: a scoreboard queues expected AW/W words
// at each accept and a negedge monitor compares them on AW/W handshakes.
module tb_fill_arbiter;
    import fill_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    logic [31:0] aw_q[$];
    logic [51:0] w_q[$];

    fill_arbiter_if bus_if();

    fill_arbiter #(
        .FILL_AXI_ID     (4'h5),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_awaddr(input logic [31:0] a);
        logic [31:0] r;
        r       = 32'h0;
        r[15:0] = a[15:0];
        return r;
    endfunction

    function automatic logic [51:0] exp_wdata(input logic [31:0] a, input logic [31:0] d,
                                              input logic dirty);
        return {1'b1, dirty, a[31:16], 2'b00, d};
    endfunction

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_b(input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.bvalid_i = 1'b1;
            to_next();
        end
        bus_if.bvalid_i = 1'b0;
    endtask

    // Offer one request until accepted; returns just after the accept edge.
    task automatic send(input logic src, input logic [31:0] a, input logic [31:0] d,
                        input logic with_b);
        logic got;
        got = 1'b0;
        if (src == 1'b0) begin
            bus_if.fill_valid_i = 1'b1;
            bus_if.fill_data_i  = {a, d};
        end else begin
            bus_if.refill_valid_i = 1'b1;
            bus_if.refill_data_i  = {a, d};
        end
        bus_if.bvalid_i = with_b;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((src == 1'b0 && bus_if.fill_ready_o) || (src == 1'b1 && bus_if.refill_ready_o)) begin
                got = 1'b1;
                aw_q.push_back(exp_awaddr(a));
                w_q.push_back(exp_wdata(a, d, (src == 1'b0)));
            end
            to_next();
            bus_if.bvalid_i = 1'b0;
        end
        bus_if.fill_valid_i   = 1'b0;
        bus_if.refill_valid_i = 1'b0;
        check("accepted", got, 1);
    endtask

    // Scoreboard side: compare each AW/W handshake with the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.awvalid_o && bus_if.awready_i) begin
                check("aw_expected", (aw_q.size() != 0), 1);
                if (aw_q.size() != 0) check("awaddr", bus_if.awaddr_o, aw_q.pop_front());
            end
            if (bus_if.wvalid_o && bus_if.wready_i) begin
                check("w_expected", (w_q.size() != 0), 1);
                if (w_q.size() != 0) check("wdata", bus_if.wdata_o, w_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] exp_seq;
        logic       got_src;
        int         nf;
        int         nr;
        int         idx;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst                   = 1'b1;
        bus_if.fill_valid_i   = 1'b0;
        bus_if.fill_data_i    = 64'h0;
        bus_if.refill_valid_i = 1'b0;
        bus_if.refill_data_i  = 64'h0;
        bus_if.awready_i      = 1'b1;
        bus_if.wready_i       = 1'b1;
        bus_if.bid_i          = 4'h0;
        bus_if.bvalid_i       = 1'b0;

        // Reset state
        to_next();
        to_next();
        @(negedge clk);
        check("rst_awvalid", bus_if.awvalid_o, 0);
        check("rst_wvalid",  bus_if.wvalid_o, 0);
        check("rst_awaddr",  bus_if.awaddr_o, 0);
        check("rst_wdata",   bus_if.wdata_o, 0);
        check("rst_awid",    bus_if.awid_o, 5);
        check("rst_wlast",   bus_if.wlast_o, 1);
        check("rst_bready",  bus_if.bready_o, 1);
        check("rst_cnt",     dut.out_cnt_r, 0);
        check("rst_state",   dut.state_r, S_IDLE);
        to_next();
        rst = 1'b0;

        // Single fill: valids at N+1, idle again at N+2
        send(1'b0, 32'hABCD_1240, 32'h5555_5555, 1'b0);
        @(negedge clk);
        check("fill_awvalid_n1", bus_if.awvalid_o, 1);
        check("fill_wvalid_n1",  bus_if.wvalid_o, 1);
        check("fill_state_n1",   dut.state_r, S_ISSUE);
        to_next();
        @(negedge clk);
        check("fill_awvalid_n2", bus_if.awvalid_o, 0);
        check("fill_wvalid_n2",  bus_if.wvalid_o, 0);
        check("fill_state_n2",   dut.state_r, S_IDLE);
        to_next();

        // Single refill, same address: DIRTY=0
        send(1'b1, 32'hABCD_1240, 32'h5555_5555, 1'b0);
        to_next();
        pulse_b(2);
        check("cnt_after_b", dut.out_cnt_r, 0);

        // Both sources valid for 4 requests each
`ifdef FILL_ARB_RR_EN
        exp_seq = 8'hAA;
`else
        exp_seq = 8'h0F;
`endif
        nf = 0;
        nr = 0;
        idx = 0;
        bus_if.fill_valid_i   = 1'b1;
        bus_if.fill_data_i    = {32'h1111_0040, 32'hF000_0000};
        bus_if.refill_valid_i = 1'b1;
        bus_if.refill_data_i  = {32'h2222_0080, 32'hE000_0000};
        for (int c = 0; c < 40 && idx < 8; c++) begin
            @(negedge clk);
            check("ready_onehot", bus_if.fill_ready_o & bus_if.refill_ready_o, 0);
            if (bus_if.fill_ready_o || bus_if.refill_ready_o) begin
                got_src = bus_if.refill_ready_o;
                check("grant_order", got_src, exp_seq[idx]);
                if (got_src) begin
                    aw_q.push_back(exp_awaddr(bus_if.refill_data_i[63:32]));
                    w_q.push_back(exp_wdata(bus_if.refill_data_i[63:32], bus_if.refill_data_i[31:0], 1'b0));
                    nr++;
                end else begin
                    aw_q.push_back(exp_awaddr(bus_if.fill_data_i[63:32]));
                    w_q.push_back(exp_wdata(bus_if.fill_data_i[63:32], bus_if.fill_data_i[31:0], 1'b1));
                    nf++;
                end
                idx++;
            end
            to_next();
            bus_if.fill_valid_i   = (nf < 4);
            bus_if.fill_data_i    = {32'h1111_0040 + 32'(nf << 6), 32'hF000_0000 + 32'(nf)};
            bus_if.refill_valid_i = (nr < 4);
            bus_if.refill_data_i  = {32'h2222_0080 + 32'(nr << 6), 32'hE000_0000 + 32'(nr)};
        end
        bus_if.fill_valid_i   = 1'b0;
        bus_if.refill_valid_i = 1'b0;
        check("grant_total", idx, 8);
        to_next();
        pulse_b(8);
        check("cnt_drain1", dut.out_cnt_r, 0);

        // Back-pressure on W until N+5
        bus_if.wready_i = 1'b0;
        send(1'b0, 32'h0BAD_3FC0, 32'h1234_5678, 1'b0);
        bus_if.fill_valid_i = 1'b1;
        bus_if.fill_data_i  = {32'h0BAD_4000, 32'h8765_4321};
        @(negedge clk);
        check("bp_awvalid_n1", bus_if.awvalid_o, 1);
        check("bp_wvalid_n1",  bus_if.wvalid_o, 1);
        check("bp_ready_n1",   bus_if.fill_ready_o, 0);
        for (int k = 2; k <= 4; k++) begin
            to_next();
            @(negedge clk);
            check("bp_awvalid_low", bus_if.awvalid_o, 0);
            check("bp_wvalid_high", bus_if.wvalid_o, 1);
            check("bp_wdata_stable", bus_if.wdata_o, exp_wdata(32'h0BAD_3FC0, 32'h1234_5678, 1'b1));
            check("bp_ready_low", bus_if.fill_ready_o, 0);
        end
        to_next();
        bus_if.wready_i = 1'b1;
        @(negedge clk);
        check("bp_wvalid_n5", bus_if.wvalid_o, 1);
        check("bp_ready_n5",  bus_if.fill_ready_o, 0);
        to_next();
        @(negedge clk);
        check("bp_ready_n6", bus_if.fill_ready_o, 1);
        if (bus_if.fill_ready_o) begin
            aw_q.push_back(exp_awaddr(32'h0BAD_4000));
            w_q.push_back(exp_wdata(32'h0BAD_4000, 32'h8765_4321, 1'b1));
        end
        to_next();
        bus_if.fill_valid_i = 1'b0;
        to_next();
        pulse_b(2);
        check("cnt_drain2", dut.out_cnt_r, 0);

        // Credit limit
        for (int k = 0; k < 8; k++) begin
            send(1'b0, 32'h3000_0000 + 32'(k << 6), 32'hC0DE_0000 + 32'(k), 1'b0);
            to_next();
        end
        check("cnt_full", dut.out_cnt_r, 8);
        bus_if.fill_valid_i   = 1'b1;
        bus_if.fill_data_i    = {32'h3000_0F00, 32'hDEAD_0000};
        bus_if.refill_valid_i = 1'b1;
        bus_if.refill_data_i  = {32'h3000_0F40, 32'hDEAD_0001};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("full_fill_ready",   bus_if.fill_ready_o, 0);
            check("full_refill_ready", bus_if.refill_ready_o, 0);
            to_next();
        end
        bus_if.fill_valid_i   = 1'b0;
        bus_if.refill_valid_i = 1'b0;
        pulse_b(1);
        check("cnt_after_one_b", dut.out_cnt_r, 7);
        send(1'b0, 32'h3000_1000, 32'hC0DE_0100, 1'b0);
        to_next();
        check("cnt_refull", dut.out_cnt_r, 8);
        bus_if.fill_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("refull_ready", bus_if.fill_ready_o, 0);
            to_next();
        end
        bus_if.fill_valid_i = 1'b0;
        pulse_b(1);
        send(1'b1, 32'h3000_2000, 32'hC0DE_0200, 1'b1);
        to_next();
        check("cnt_accept_plus_b", dut.out_cnt_r, 7);
        pulse_b(7);
        check("cnt_drain3", dut.out_cnt_r, 0);

        // Reset while in S_ISSUE, then a stray B
        bus_if.awready_i = 1'b0;
        bus_if.wready_i  = 1'b0;
        send(1'b0, 32'h4444_0000, 32'h0000_0001, 1'b0);
        @(negedge clk);
        check("issue_awvalid", bus_if.awvalid_o, 1);
        check("issue_cnt", dut.out_cnt_r, 1);
        to_next();
        rst = 1'b1;
        to_next();
        @(negedge clk);
        check("rst_issue_awvalid", bus_if.awvalid_o, 0);
        check("rst_issue_wvalid",  bus_if.wvalid_o, 0);
        check("rst_issue_cnt",     dut.out_cnt_r, 0);
        check("rst_issue_state",   dut.state_r, S_IDLE);
        aw_q.delete();
        w_q.delete();
        to_next();
        rst              = 1'b0;
        bus_if.awready_i = 1'b1;
        bus_if.wready_i  = 1'b1;
        pulse_b(1);
        check("stray_b_cnt", dut.out_cnt_r, 0);

        to_next();
        check("aw_q_drained", aw_q.size(), 0);
        check("w_q_drained",  w_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
